// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the htar9 run controller: state encoding and default limits.
package run_ctrl_pkg;

  // ST_ prefixes keep the TIMEOUT state name clear of the TIMEOUT parameter
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } run_state_t;

  localparam int unsigned DEFAULT_INIT_CYCLES = 2;
  localparam logic [15:0] DEFAULT_TIMEOUT     = 16'd1000;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// 16-bit cycle counter with clear, enable and a look-ahead compare against a limit.
module sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic        next_at_limit
);

  logic [15:0] count_inc;

  assign count_inc     = count + 16'd1;
  assign next_at_limit = (count_inc == limit);

  // Holding at the limit guarantees the count can never wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && (count != limit)) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Sequences the htar9 core through init, run and completion, and arbitrates
// the data-memory port between the host and the core.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = DEFAULT_INIT_CYCLES,
  parameter logic [15:0] TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        core_done,
  input  logic        host_req,
  output logic        core_init,
  output logic        busy,
  output logic        finished,
  output logic        timed_out,
  output logic [15:0] cycle_count,
  output logic        host_gnt,
  output logic        dm_sel
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  run_state_t  state;
  logic [3:0]  init_cnt;
  logic        core_init_q;
  logic        host_window;
  logic        start_run;
  logic        cnt_enable;
  logic        cnt_hit;

  assign host_window = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_TIMEOUT);
  assign start_run   = start && host_window;
  assign cnt_enable  = (state == ST_RUN) && !abort && !core_done;

  sat_counter u_cycle_counter (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_run),
    .enable        (cnt_enable),
    .limit         (TIMEOUT),
    .count         (cycle_count),
    .next_at_limit (cnt_hit)
  );

  // Priority in RUN is abort, then done, then timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      init_cnt    <= 4'd0;
      core_init_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start) begin
            state    <= ST_INIT;
            init_cnt <= 4'd0;
          end
        end
        ST_INIT: begin
          init_cnt <= init_cnt + 4'd1;
          if (init_cnt == INIT_LAST) begin
            state       <= ST_RUN;
            core_init_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state       <= ST_IDLE;
            core_init_q <= 1'b1;
          end else if (core_done) begin
            state       <= ST_DONE;
            core_init_q <= 1'b1;
          end else if (cnt_hit) begin
            state       <= ST_TIMEOUT;
            core_init_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          core_init_q <= 1'b1;
        end
      endcase
    end
  end

  assign core_init = core_init_q;
  assign busy      = (state == ST_INIT) || (state == ST_RUN);
  assign finished  = (state == ST_DONE);
  assign timed_out = (state == ST_TIMEOUT);
  assign host_gnt  = host_req && host_window;
  assign dm_sel    = host_gnt;

endmodule
